usb_txn_ctrl: RTL and testbench
===============================

# usb_txn_ctrl

Host-side USB transaction sequencer that sits above the bit-serial packet encoder and beside the receive decoder. It accepts one OUT or IN transaction request at a time and builds each 99-bit packet image for the encoder. Packets are a token, then DATA0 or ACK. The block handles the encoder's load/complete handshake, waits for the device's response with a timeout, and retries NAKed, corrupt or silent attempts up to a limit before reporting completion upstream.

## Interface
- TIMEOUT, 255: maximum cycles to wait for a device response (range 1-1023).
- MAX_TRY, 8: total attempts per transaction, including the first (range 1-15).
- clk  in  1  system clock, all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  transaction request present.
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready.
- req_is_in  in  1  1 = IN transaction, 0 = OUT.
- req_addr  in  7  device address.
- req_endp  in  4  endpoint.
- req_data  in  64  OUT payload (ignored for IN).
- done  out  1  one-cycle completion pulse.
- done_ok  out  1  valid with done: 1 = ACKed OUT or good IN data, 0 = attempts exhausted.
- done_data  out  64  IN payload, valid with done & done_ok.
- enc_pkt  out  99  registered packet image to encoder.
- enc_avail  out  1  encoder pktInAvail.
- enc_ready_in  in  1  encoder readyIn (high in its Wait/Done states).
- rx_valid  in  1  one-cycle pulse: decoder has a complete packet.
- rx_pid  in  4  received PID in USB order (ACK 4'b0010, NAK 4'b1010, DATA0 4'b0011).
- rx_data  in  64  received payload.
- rx_crc_ok  in  1  received CRC16 check passed.

## Operation
- Packet image, all unlisted bits 0:
  - [98:91] = 8'b00000001.
  - [90:87] = PID bit-reversed (PID[0] at bit 90).
  - [86:83] = ~[90:87].
- PID values: OUT 0001, IN 1001, DATA0 0011, ACK 0010.
- Token packet: [82:76] = req_addr bit-reversed (addr[0] at 82); [75:72] = req_endp bit-reversed.
- Data packet: [82:19] = req_data bit-reversed (data[0] at 82); the CRC field [18:3] is left 0 because the encoder fills it.
- Request fields are latched on acceptance. The try counter (4 bits) clears to 1.
- States:
  - IDLE -> SEND_TOK on accept.
  - SEND_x: enc_pkt holds packet x and enc_avail=1. Transition to WAIT_x at the edge where enc_ready_in=1.
  - WAIT_x: enc_avail=0. A "left" flag sets when enc_ready_in=0. Exit when left & enc_ready_in=1.
  - WAIT_TOK exits to SEND_DAT for OUT, or RX_DATA for IN.
  - WAIT_DAT -> RX_HS.
  - RX_HS (OUT): rx_valid & PID=ACK -> DONE with ok=1. NAK, any other PID, or timeout -> RETRY.
  - RX_DATA (IN): rx_valid & PID=DATA0 & rx_crc_ok captures rx_data and goes to SEND_ACK. NAK, bad CRC, other PID, or timeout -> RETRY. No handshake is sent on failure.
  - SEND_ACK -> WAIT_ACK -> DONE with ok=1.
  - RETRY (1 cycle): if try == MAX_TRY, go to DONE with ok=0. Otherwise increment try and go to SEND_TOK.
  - DONE (1 cycle): done=1, then IDLE.
- Timeout counter (10 bits) clears on entry to RX_HS or RX_DATA and increments each cycle there. Expiry occurs when count == TIMEOUT.
- rx_valid and timeout on the same cycle: rx_valid wins.
- rx_valid outside the RX_* states is ignored.

## Timing
- Reset: state IDLE; req_ready=1; done=0, done_ok=0, done_data=0, enc_pkt=0, enc_avail=0; counters 0.
- Reset mid-transaction aborts immediately with no done pulse. enc_avail drops asynchronously.
- Request accepted at edge N: enc_avail=1 and enc_pkt valid in cycle N+1.
- enc_pkt stays stable from SEND_x through the last WAIT_x cycle.
- enc_avail is high only in SEND_x and never for more than one cycle after enc_ready_in=1.
- done, done_ok and done_data are registered outputs, valid together for exactly one cycle. req_ready rises the cycle after done.
- Maximum attempts is MAX_TRY. A MAX_TRY=1 failure goes directly to DONE with ok=0.

## Test plan
- OUT, addr 7'h05, endp 4'h1, data 64'h0123456789ABCDEF, device ACKs:
  - token image [90:83] = 8'b10000111, [82:72] = 11'b10100001000.
  - data [90:83] = 8'b11000011.
  - done=1, done_ok=1, exactly 2 enc_avail pulses.
- OUT, device NAKs twice then ACKs -> 3 token + 3 data packets, done_ok=1.
- OUT, device silent, TIMEOUT=20, MAX_TRY=8 -> 8 token/data pairs, each RX_HS wait exactly 20 cycles, then done_ok=0.
- IN, device returns DATA0 with rx_crc_ok=0, then DATA0 with payload 64'hDEADBEEFCAFEF00D and rx_crc_ok=1:
  - 2 IN tokens, ACK image [90:83] = 8'b01001011.
  - done_data = 64'hDEADBEEFCAFEF00D.
- rx_valid ACK on the same cycle as timeout expiry -> treated as ACK, done_ok=1.
- rst asserted during WAIT_DAT:
  - next cycle enc_avail=0, req_ready=1, no done pulse.
  - a fresh request then completes normally.

Source files
------------

// File: rtl/usb_txn_ctrl_if.sv
// Request, completion, encoder and decoder signals of the USB transaction
// sequencer, bundled so the host side (master) and the sequencer (slave)
// can be wired with a single port.
`timescale 1ns/1ps
interface usb_txn_ctrl_if;
  // upstream request
  logic        req_valid;
  logic        req_ready;
  logic        req_is_in;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [63:0] req_data;
  // upstream completion
  logic        done;
  logic        done_ok;
  logic [63:0] done_data;
  // bit-serial encoder handshake
  logic [98:0] enc_pkt;
  logic        enc_avail;
  logic        enc_ready_in;
  // receive decoder
  logic        rx_valid;
  logic [3:0]  rx_pid;
  logic [63:0] rx_data;
  logic        rx_crc_ok;

  modport master (
    output req_valid, req_is_in, req_addr, req_endp, req_data,
    output enc_ready_in, rx_valid, rx_pid, rx_data, rx_crc_ok,
    input  req_ready, done, done_ok, done_data, enc_pkt, enc_avail
  );

  modport slave (
    input  req_valid, req_is_in, req_addr, req_endp, req_data,
    input  enc_ready_in, rx_valid, rx_pid, rx_data, rx_crc_ok,
    output req_ready, done, done_ok, done_data, enc_pkt, enc_avail
  );
endinterface

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer. Accepts one OUT/IN request at a time,
// builds token / DATA0 / ACK packet images for the bit-serial encoder,
// waits for the device response with a timeout and retries failed attempts
// up to MAX_TRY before pulsing done.
`timescale 1ns/1ps
module usb_txn_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned MAX_TRY = 8
) (
  input logic           clk,
  input logic           rst,
  usb_txn_ctrl_if.slave bus
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [9:0] TMO_LIM   = 10'(TIMEOUT);
  localparam logic [3:0] TRY_LIM   = 4'(MAX_TRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_TOK,
    S_WAIT_TOK,
    S_SEND_DAT,
    S_WAIT_DAT,
    S_RX_HS,
    S_RX_DATA,
    S_SEND_ACK,
    S_WAIT_ACK,
    S_RETRY,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;

  logic        is_in_q;
  logic [6:0]  addr_q;
  logic [3:0]  endp_q;
  logic [63:0] data_q;
  logic [63:0] rx_data_q;
  logic [3:0]  try_q;
  logic [9:0]  tmo_q;
  logic        left_q;
  logic [98:0] pkt_q;
  logic [98:0] pkt_n;
  logic        done_q;
  logic        done_ok_q;
  logic [63:0] done_data_q;

  logic        accept;
  logic        in_send;
  logic        in_wait;
  logic        in_rx;
  logic        wait_exit;
  logic        tmo_hit;
  logic        rx_is_ack;
  logic        rx_is_good_data;
  logic        capture;
  logic        finish_ok;

  // Sync byte plus bit-reversed PID and its complement; all other bits zero.
  function automatic logic [98:0] pkt_hdr(input logic [3:0] pid);
    logic [98:0] p;
    p = '0;
    p[98:91] = 8'b0000_0001;
    for (int unsigned i = 0; i < 4; i++) begin
      p[90 - i] = pid[i];
    end
    p[86:83] = ~p[90:87];
    return p;
  endfunction

  function automatic logic [98:0] tok_pkt(input logic [3:0] pid,
                                          input logic [6:0] addr,
                                          input logic [3:0] endp);
    logic [98:0] p;
    p = pkt_hdr(pid);
    for (int unsigned i = 0; i < 7; i++) begin
      p[82 - i] = addr[i];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      p[75 - i] = endp[i];
    end
    return p;
  endfunction

  // CRC16 field [18:3] stays zero; the encoder inserts it.
  function automatic logic [98:0] dat_pkt(input logic [63:0] data);
    logic [98:0] p;
    p = pkt_hdr(PID_DATA0);
    for (int unsigned i = 0; i < 64; i++) begin
      p[82 - i] = data[i];
    end
    return p;
  endfunction

  assign accept          = (state == S_IDLE) && bus.req_valid;
  assign in_send         = state inside {S_SEND_TOK, S_SEND_DAT, S_SEND_ACK};
  assign in_wait         = state inside {S_WAIT_TOK, S_WAIT_DAT, S_WAIT_ACK};
  assign in_rx           = state inside {S_RX_HS, S_RX_DATA};
  assign wait_exit       = left_q && bus.enc_ready_in;
  assign tmo_hit         = (tmo_q == TMO_LIM);
  assign rx_is_ack       = (bus.rx_pid == PID_ACK);
  assign rx_is_good_data = (bus.rx_pid == PID_DATA0) && bus.rx_crc_ok;

  // Next-state, packet image selection and completion status.
  always_comb begin
    state_n   = state;
    pkt_n     = pkt_q;
    capture   = 1'b0;
    finish_ok = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_SEND_TOK;
          pkt_n   = tok_pkt(bus.req_is_in ? PID_IN : PID_OUT,
                            bus.req_addr, bus.req_endp);
        end
      end
      S_SEND_TOK: if (bus.enc_ready_in) state_n = S_WAIT_TOK;
      S_WAIT_TOK: begin
        if (wait_exit) begin
          if (is_in_q) begin
            state_n = S_RX_DATA;
          end else begin
            state_n = S_SEND_DAT;
            pkt_n   = dat_pkt(data_q);
          end
        end
      end
      S_SEND_DAT: if (bus.enc_ready_in) state_n = S_WAIT_DAT;
      S_WAIT_DAT: if (wait_exit) state_n = S_RX_HS;
      // rx_valid is tested before the timeout so a response on the expiry
      // cycle still counts.
      S_RX_HS: begin
        if (bus.rx_valid) begin
          if (rx_is_ack) begin
            state_n   = S_DONE;
            finish_ok = 1'b1;
          end else begin
            state_n = S_RETRY;
          end
        end else if (tmo_hit) begin
          state_n = S_RETRY;
        end
      end
      S_RX_DATA: begin
        if (bus.rx_valid) begin
          if (rx_is_good_data) begin
            state_n = S_SEND_ACK;
            capture = 1'b1;
            pkt_n   = pkt_hdr(PID_ACK);
          end else begin
            state_n = S_RETRY;
          end
        end else if (tmo_hit) begin
          state_n = S_RETRY;
        end
      end
      S_SEND_ACK: if (bus.enc_ready_in) state_n = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (wait_exit) begin
          state_n   = S_DONE;
          finish_ok = 1'b1;
        end
      end
      S_RETRY: begin
        if (try_q == TRY_LIM) begin
          state_n = S_DONE;
        end else begin
          state_n = S_SEND_TOK;
          pkt_n   = tok_pkt(is_in_q ? PID_IN : PID_OUT, addr_q, endp_q);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Request latches, try/timeout counters, encoder-left flag and packet image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_in_q   <= 1'b0;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      rx_data_q <= '0;
      try_q     <= '0;
      tmo_q     <= '0;
      left_q    <= 1'b0;
      pkt_q     <= '0;
    end else begin
      pkt_q <= pkt_n;
      if (accept) begin
        is_in_q <= bus.req_is_in;
        addr_q  <= bus.req_addr;
        endp_q  <= bus.req_endp;
        data_q  <= bus.req_data;
        try_q   <= 4'd1;
      end else if ((state == S_RETRY) && (state_n == S_SEND_TOK)) begin
        try_q <= try_q + 4'd1;
      end
      // Held at zero outside the receive states, so it is zero on entry.
      tmo_q  <= in_rx ? tmo_q + 10'd1 : '0;
      // Cleared while offering a packet; set once the encoder goes busy.
      left_q <= in_wait ? (left_q | ~bus.enc_ready_in) : 1'b0;
      if (capture) begin
        rx_data_q <= bus.rx_data;
      end
    end
  end

  // Registered completion outputs, valid only in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      done_ok_q   <= 1'b0;
      done_data_q <= '0;
    end else begin
      done_q      <= (state_n == S_DONE);
      done_ok_q   <= (state_n == S_DONE) && finish_ok;
      done_data_q <= ((state_n == S_DONE) && finish_ok && is_in_q) ? rx_data_q : '0;
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.enc_avail = in_send;
  assign bus.enc_pkt   = pkt_q;
  assign bus.done      = done_q;
  assign bus.done_ok   = done_ok_q;
  assign bus.done_data = done_data_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Scoreboard bench for usb_txn_ctrl: an encoder/device model answers each
// attempt from a per-attempt action queue; expected packets and completions
// are queued when a transaction is issued and checked by monitors.
`timescale 1ns/1ps
module tb_usb_txn_ctrl;
  localparam int unsigned TMO  = 20;
  localparam int unsigned MTRY = 8;

  localparam int A_GOOD   = 0;  // ACK (OUT) / good DATA0 (IN) inside the window
  localparam int A_NAK    = 1;
  localparam int A_OTHER  = 2;  // wrong PID
  localparam int A_SILENT = 3;
  localparam int A_BADCRC = 4;  // DATA0 with failed CRC (IN only)
  localparam int A_EDGE   = 5;  // good response on the timeout-expiry cycle
  localparam int A_LATE   = 6;  // good response one cycle after expiry

  localparam int K_TOK = 0;
  localparam int K_DAT = 1;
  localparam int K_ACK = 2;

  typedef struct {
    logic        ok;
    logic        is_in;
    logic [63:0] data;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_txn_ctrl_if bus();

  usb_txn_ctrl #(.TIMEOUT(TMO), .MAX_TRY(MTRY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [98:0] pkt_q[$];
  int          act_q[$];
  logic [63:0] pay_q[$];
  done_t       done_q[$];
  int          plan[$];
  logic        cur_is_in = 1'b0;
  logic [98:0] last_pkt[3];
  int          pkt_cnt = 0;
  int          dat_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Low n bits of x, reversed, in the low n bits of the result.
  function automatic logic [63:0] rev(input logic [63:0] x, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[62:0], x[0]};
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic logic [98:0] tok_img(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e);
    logic [63:0] rp;
    logic [63:0] ra;
    logic [63:0] re;
    rp = rev(64'(pid), 4);
    ra = rev(64'(a), 7);
    re = rev(64'(e), 4);
    return {8'h01, rp[3:0], ~rp[3:0], ra[6:0], re[3:0], 72'd0};
  endfunction

  function automatic logic [98:0] dat_img(input logic [63:0] d);
    logic [63:0] rp;
    rp = rev(64'(4'b0011), 4);
    return {8'h01, rp[3:0], ~rp[3:0], rev(d, 64), 19'd0};
  endfunction

  function automatic logic [98:0] ack_img();
    logic [63:0] rp;
    rp = rev(64'(4'b0010), 4);
    return {8'h01, rp[3:0], ~rp[3:0], 83'd0};
  endfunction

  function automatic logic is_good(input int a);
    return (a == A_GOOD) || (a == A_EDGE);
  endfunction

  // Encoder + device model: encoder takes a packet when offered while ready,
  // goes busy for a few cycles; at the end of each attempt's send phase the
  // device answers according to the next queued action.
  initial begin
    int          busy = 0;
    int          rx_cd = 0;
    int          kind = K_TOK;
    int          next_kind = K_TOK;
    int          r_act = A_SILENT;
    logic        drop = 1'b0;
    logic [63:0] r_pay = '0;
    logic [98:0] exp_pkt;
    bus.enc_ready_in = 1'b1;
    bus.rx_valid     = 1'b0;
    bus.rx_pid       = '0;
    bus.rx_data      = '0;
    bus.rx_crc_ok    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; rx_cd = 0; kind = K_TOK; next_kind = K_TOK; drop = 1'b0;
        bus.enc_ready_in = 1'b1;
        bus.rx_valid     = 1'b0;
      end else begin
        bus.rx_valid = 1'b0;
        if (rx_cd > 0) begin
          rx_cd--;
          if (rx_cd == 0) begin
            bus.rx_valid  = 1'b1;
            bus.rx_crc_ok = 1'b1;
            bus.rx_data   = r_pay;
            case (r_act)
              A_NAK:    bus.rx_pid = 4'b1010;
              A_OTHER:  bus.rx_pid = cur_is_in ? 4'b0010 : 4'b0011;
              A_BADCRC: begin bus.rx_pid = 4'b0011; bus.rx_crc_ok = 1'b0; end
              default:  bus.rx_pid = cur_is_in ? 4'b0011 : 4'b0010;
            endcase
          end
        end
        if (drop) begin
          drop = 1'b0;
          chk("avail_after_take", 128'(bus.enc_avail), 128'(0));
          bus.enc_ready_in = 1'b0;
        end else if (!bus.enc_ready_in) begin
          if (busy > 0) begin
            busy--;
          end else begin
            bus.enc_ready_in = 1'b1;
            if (kind == K_TOK && !cur_is_in) begin
              next_kind = K_DAT;
            end else if (kind == K_ACK) begin
              next_kind = K_TOK;
            end else begin
              if (act_q.size() == 0) begin
                chk("unexpected_attempt", 128'(1), 128'(0));
                r_act = A_SILENT;
              end else begin
                r_act = act_q.pop_front();
                r_pay = pay_q.pop_front();
              end
              case (r_act)
                A_SILENT: rx_cd = 0;
                A_EDGE:   rx_cd = TMO + 1;
                A_LATE:   rx_cd = TMO + 2;
                default:  rx_cd = int'($urandom_range(0, TMO - 1)) + 1;
              endcase
              next_kind = (cur_is_in && is_good(r_act)) ? K_ACK : K_TOK;
            end
          end
        end else if (bus.enc_avail) begin
          pkt_cnt++;
          if (pkt_q.size() == 0) begin
            chk("unexpected_pkt", 128'(1), 128'(0));
          end else begin
            exp_pkt = pkt_q.pop_front();
            chk("pkt_image", 128'(bus.enc_pkt), 128'(exp_pkt));
          end
          kind = next_kind;
          last_pkt[kind] = bus.enc_pkt;
          if (kind == K_DAT) dat_seen++;
          drop = 1'b1;
          busy = int'($urandom_range(0, 3));
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    logic  prev = 1'b0;
    done_t dx;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (prev) begin
          chk("ready_after_done", 128'(bus.req_ready), 128'(1));
          chk("done_one_cycle", 128'(bus.done), 128'(0));
        end
        if (bus.done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 128'(1), 128'(0));
          end else begin
            dx = done_q.pop_front();
            chk("done_ok", 128'(bus.done_ok), 128'(dx.ok));
            if (dx.ok && dx.is_in) chk("done_data", 128'(bus.done_data), 128'(dx.data));
          end
        end
        prev = bus.done;
      end
    end
  end

  // Queue the expected packets, device actions and completion for one
  // transaction from the global attempt plan.
  task automatic expect_txn(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d, input logic [63:0] pay);
    done_t dx;
    logic  ok;
    int    act;
    ok = 1'b0;
    while (plan.size() < MTRY) plan.push_back(A_SILENT);
    for (int i = 0; i < int'(MTRY) && !ok; i++) begin
      act = plan[i];
      act_q.push_back(act);
      pay_q.push_back(is_good(act) ? pay : {$urandom, $urandom});
      pkt_q.push_back(tok_img(is_in ? 4'b1001 : 4'b0001, a, e));
      if (!is_in) pkt_q.push_back(dat_img(d));
      if (is_good(act)) begin
        ok = 1'b1;
        if (is_in) pkt_q.push_back(ack_img());
      end
    end
    dx.ok    = ok;
    dx.is_in = is_in;
    dx.data  = pay;
    done_q.push_back(dx);
    plan.delete();
    cur_is_in = is_in;
  endtask

  task automatic issue_req(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!bus.req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_idle", 128'(bus.req_ready), 128'(1));
    bus.req_valid = 1'b1;
    bus.req_is_in = is_in;
    bus.req_addr  = a;
    bus.req_endp  = e;
    bus.req_data  = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_is_in = 1'($urandom);
    bus.req_addr  = 7'($urandom);
    bus.req_endp  = 4'($urandom);
    bus.req_data  = {$urandom, $urandom};
    chk("ready_low_after_accept", 128'(bus.req_ready), 128'(0));
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (done_q.size() != 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 6000) begin
      chk("txn_timeout", 128'(done_q.size()), 128'(0));
      pkt_q.delete(); act_q.delete(); pay_q.delete(); done_q.delete();
    end
    chk("pkts_consumed", 128'(pkt_q.size()), 128'(0));
    chk("attempts_consumed", 128'(act_q.size()), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic run_txn(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                         input logic [63:0] d, input logic [63:0] pay);
    expect_txn(is_in, a, e, d, pay);
    issue_req(is_in, a, e, d);
    wait_done();
  endtask

  initial begin
    int p0;
    int cyc;
    logic        r_in;
    logic [63:0] r_d;
    bus.req_valid = 1'b0;
    bus.req_is_in = 1'b0;
    bus.req_addr  = '0;
    bus.req_endp  = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(bus.req_ready), 128'(1));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_done_ok", 128'(bus.done_ok), 128'(0));
    chk("rst_done_data", 128'(bus.done_data), 128'(0));
    chk("rst_enc_pkt", 128'(bus.enc_pkt), 128'(0));
    chk("rst_enc_avail", 128'(bus.enc_avail), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // OUT acked first time
    p0 = pkt_cnt;
    plan = {A_GOOD};
    run_txn(1'b0, 7'h05, 4'h1, 64'h0123456789ABCDEF, 64'd0);
    chk("out_pkt_count", 128'(pkt_cnt - p0), 128'(2));
    chk("tok_pid_field", 128'(last_pkt[K_TOK][90:83]), 128'(8'b10000111));
    chk("tok_addr_endp", 128'(last_pkt[K_TOK][82:72]), 128'(11'b10100001000));
    chk("dat_pid_field", 128'(last_pkt[K_DAT][90:83]), 128'(8'b11000011));

    // OUT NAK, NAK, ACK
    p0 = pkt_cnt;
    plan = {A_NAK, A_NAK, A_GOOD};
    run_txn(1'b0, 7'h3A, 4'h7, 64'hFEDCBA9876543210, 64'd0);
    chk("nak2_pkt_count", 128'(pkt_cnt - p0), 128'(6));

    // OUT device silent on every attempt
    p0 = pkt_cnt;
    run_txn(1'b0, 7'h11, 4'h2, 64'h5555AAAA0000FFFF, 64'd0);
    chk("silent_pkt_count", 128'(pkt_cnt - p0), 128'(2 * MTRY));

    // IN: bad CRC then good DATA0
    p0 = pkt_cnt;
    plan = {A_BADCRC, A_GOOD};
    run_txn(1'b1, 7'h22, 4'h3, 64'd0, 64'hDEADBEEFCAFEF00D);
    chk("in_pkt_count", 128'(pkt_cnt - p0), 128'(3));
    chk("ack_pid_field", 128'(last_pkt[K_ACK][90:83]), 128'(8'b01001011));

    // ACK on the expiry cycle wins; one cycle later it is ignored
    plan = {A_EDGE};
    run_txn(1'b0, 7'h40, 4'h9, 64'h1, 64'd0);
    plan = {A_LATE, A_GOOD};
    run_txn(1'b0, 7'h41, 4'hA, 64'h2, 64'd0);
    plan = {A_LATE, A_OTHER, A_NAK, A_EDGE};
    run_txn(1'b1, 7'h42, 4'hB, 64'd0, 64'h0F0F_1234_5678_9ABC);

    // reset while waiting for the data packet to be sent
    plan = {A_SILENT};
    expect_txn(1'b0, 7'h55, 4'h5, 64'hA5A5A5A5A5A5A5A5, 64'd0);
    p0 = dat_seen;
    issue_req(1'b0, 7'h55, 4'h5, 64'hA5A5A5A5A5A5A5A5);
    cyc = 0;
    while (dat_seen == p0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_wait_dat", 128'(dat_seen - p0), 128'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_enc_avail", 128'(bus.enc_avail), 128'(0));
    chk("midrst_req_ready", 128'(bus.req_ready), 128'(1));
    chk("midrst_done", 128'(bus.done), 128'(0));
    pkt_q.delete(); act_q.delete(); pay_q.delete(); done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    plan = {A_GOOD};
    run_txn(1'b0, 7'h66, 4'h6, 64'h0BADF00D12345678, 64'd0);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      r_in = 1'($urandom);
      r_d  = {$urandom, $urandom};
      for (int i = 0; i < int'(MTRY); i++) begin
        case ($urandom_range(0, 9))
          0, 1:    plan.push_back(A_GOOD);
          2:       plan.push_back(A_EDGE);
          3, 4:    plan.push_back(A_NAK);
          5:       plan.push_back(A_OTHER);
          6:       plan.push_back(A_SILENT);
          7:       plan.push_back(A_LATE);
          default: plan.push_back(r_in ? A_BADCRC : A_NAK);
        endcase
      end
      run_txn(r_in, 7'($urandom), 4'($urandom), r_in ? 64'd0 : r_d,
              r_in ? r_d : 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
